// File: rtl/id_pkg.sv
// Shared constants and types for the decode/issue stage: opcodes, widths,
// hazard FSM states, decoded control bundle and the ID/EX register layout.
package id_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef enum logic {Run, Bubble} hz_state_e;

    typedef struct packed {
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          illegal;
        logic          uses_rt;
        logic [AW-1:0] dst;
    } ctrl_t;

    typedef struct packed {
        logic          valid;
        logic [5:0]    op;
        logic [5:0]    funct;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
        logic [DW-1:0] imm;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] dst;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          illegal;
    } ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle around the decode/issue stage: IF/ID input, register-file
// read/write snoop ports and the ID/EX outputs.
interface id_ex_stage_if import id_pkg::*; ();

    logic          if_valid;
    logic [31:0]   if_instr;
    logic          flush;
    logic          ex_ready;
    logic [AW-1:0] A1;
    logic [AW-1:0] A2;
    logic [DW-1:0] RD1;
    logic [DW-1:0] RD2;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          id_stall;
    logic          ex_valid;
    logic [5:0]    ex_op;
    logic [5:0]    ex_funct;
    logic [DW-1:0] ex_rs_val;
    logic [DW-1:0] ex_rt_val;
    logic [DW-1:0] ex_imm;
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic [AW-1:0] ex_dst;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_illegal;

    modport master (
        output if_valid, if_instr, flush, ex_ready, RD1, RD2, wb_we, wb_addr, wb_data,
        input  A1, A2, id_stall, ex_valid, ex_op, ex_funct, ex_rs_val, ex_rt_val, ex_imm,
               ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_illegal
    );

    modport slave (
        input  if_valid, if_instr, flush, ex_ready, RD1, RD2, wb_we, wb_addr, wb_data,
        output A1, A2, id_stall, ex_valid, ex_op, ex_funct, ex_rs_val, ex_rt_val, ex_imm,
               ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_illegal
    );

endinterface

// File: rtl/id_decoder.sv
// Purely combinational opcode-to-control mapping for the decode stage.
module id_decoder import id_pkg::*; (
    input  logic [5:0]    op_i,
    input  logic [AW-1:0] rt_i,
    input  logic [AW-1:0] rd_i,
    output ctrl_t         ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (op_i)
            OP_RTYPE: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.uses_rt  = 1'b1;
                ctrl_o.dst      = rd_i;
            end
            OP_LW: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memread  = 1'b1;
                ctrl_o.dst      = rt_i;
            end
            OP_SW: begin
                ctrl_o.memwrite = 1'b1;
                ctrl_o.uses_rt  = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.dst      = rt_i;
            end
            OP_BEQ:  ctrl_o.uses_rt = 1'b1;
            default: ctrl_o.illegal = 1'b1;
        endcase
        // r0 is hard-wired, so a write to it is dropped here
        if (ctrl_o.dst == '0) begin
            ctrl_o.regwrite = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: register-file read, load-use bubble FSM and ID/EX register.
// ID_WB_BYPASS_EN: forward the same-cycle WB write instead of stalling on it.
module id_ex_stage import id_pkg::*; (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus_io
);

    logic [5:0]    op;
    logic [AW-1:0] rs, rt, rd;
    ctrl_t         ctrl;
    logic          wb_hit_rs, wb_hit_rt, hz_load_use, hz;
    logic [DW-1:0] rs_src, rt_src;
    hz_state_e     state_q, state_d;
    ex_t           ex_q, ex_d, issue;
    logic          id_stall;

    assign op = bus_io.if_instr[31:26];
    assign rs = bus_io.if_instr[25:21];
    assign rt = bus_io.if_instr[20:16];
    assign rd = bus_io.if_instr[15:11];

    assign bus_io.A1 = rs;
    assign bus_io.A2 = rt;

    id_decoder u_decoder (
        .op_i   (op),
        .rt_i   (rt),
        .rd_i   (rd),
        .ctrl_o (ctrl)
    );

    assign wb_hit_rs = bus_io.wb_we && (bus_io.wb_addr != '0) && (bus_io.wb_addr == rs);
    assign wb_hit_rt = bus_io.wb_we && (bus_io.wb_addr != '0) && (bus_io.wb_addr == rt);

    assign hz_load_use = ex_q.valid && ex_q.memread && (ex_q.rt != '0) &&
                         ((ex_q.rt == rs) || ((ex_q.rt == rt) && ctrl.uses_rt));

`ifdef ID_WB_BYPASS_EN
    assign hz     = hz_load_use;
    assign rs_src = wb_hit_rs ? bus_io.wb_data : bus_io.RD1;
    assign rt_src = wb_hit_rt ? bus_io.wb_data : bus_io.RD2;
`else
    // Without forwarding, wait one cycle so the register file holds the new value
    assign hz     = hz_load_use || wb_hit_rs || wb_hit_rt;
    assign rs_src = bus_io.RD1;
    assign rt_src = bus_io.RD2;
`endif

    always_comb begin
        issue = '0;
        if (bus_io.if_valid) begin
            issue.valid    = 1'b1;
            issue.op       = op;
            issue.funct    = bus_io.if_instr[5:0];
            issue.rs_val   = (rs == '0) ? '0 : rs_src;
            issue.rt_val   = (rt == '0) ? '0 : rt_src;
            issue.imm      = {{16{bus_io.if_instr[15]}}, bus_io.if_instr[15:0]};
            issue.rs       = rs;
            issue.rt       = rt;
            issue.dst      = ctrl.dst;
            issue.regwrite = ctrl.regwrite;
            issue.memread  = ctrl.memread;
            issue.memwrite = ctrl.memwrite;
            issue.illegal  = ctrl.illegal;
        end
    end

    always_comb begin
        state_d  = state_q;
        ex_d     = ex_q;
        id_stall = 1'b0;
        if (!bus_io.ex_ready) begin
            id_stall = 1'b1;
        end else if (bus_io.flush) begin
            ex_d    = '0;
            state_d = Run;
        end else if ((state_q == Run) && bus_io.if_valid && hz) begin
            ex_d     = '0;
            id_stall = 1'b1;
            state_d  = Bubble;
        end else begin
            ex_d    = issue;
            state_d = Run;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= Run;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
        end
    end

    assign bus_io.id_stall    = id_stall;
    assign bus_io.ex_valid    = ex_q.valid;
    assign bus_io.ex_op       = ex_q.op;
    assign bus_io.ex_funct    = ex_q.funct;
    assign bus_io.ex_rs_val   = ex_q.rs_val;
    assign bus_io.ex_rt_val   = ex_q.rt_val;
    assign bus_io.ex_imm      = ex_q.imm;
    assign bus_io.ex_rs       = ex_q.rs;
    assign bus_io.ex_rt       = ex_q.rt;
    assign bus_io.ex_dst      = ex_q.dst;
    assign bus_io.ex_regwrite = ex_q.regwrite;
    assign bus_io.ex_memread  = ex_q.memread;
    assign bus_io.ex_memwrite = ex_q.memwrite;
    assign bus_io.ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage with a behavioural register file attached.
module tb_id_ex_stage;
    import id_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage u_dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    // Register file; r0 returns garbage so the stage's own zeroing is exercised
    logic [31:0] rf [32] = '{default: 32'h0};
    assign bus.RD1 = (bus.A1 == 5'd0) ? 32'hDEADBEEF : rf[bus.A1];
    assign bus.RD2 = (bus.A2 == 5'd0) ? 32'hDEADBEEF : rf[bus.A2];
    always @(posedge clk) begin
        if (bus.wb_we && bus.wb_addr != 5'd0) rf[bus.wb_addr] <= bus.wb_data;
    end

    typedef struct {
        logic [5:0]  op, funct;
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  rs, rt, dst;
        logic        rw, mr, mw, ill;
    } exp_t;

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Value the instruction must see: the write landing this cycle wins
    function automatic logic [31:0] src_val(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        return rf[a];
    endfunction

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        e.op     = ins[31:26];
        e.funct  = ins[5:0];
        e.rs     = ins[25:21];
        e.rt     = ins[20:16];
        e.rs_val = src_val(ins[25:21]);
        e.rt_val = src_val(ins[20:16]);
        e.imm    = {{16{ins[15]}}, ins[15:0]};
        e.dst = 5'd0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.ill = 1'b0;
        case (ins[31:26])
            6'h00:   begin e.rw = 1'b1; e.dst = ins[15:11]; end
            6'h23:   begin e.rw = 1'b1; e.mr = 1'b1; e.dst = ins[20:16]; end
            6'h2B:   e.mw = 1'b1;
            6'h08:   begin e.rw = 1'b1; e.dst = ins[20:16]; end
            6'h04:   ;
            default: e.ill = 1'b1;
        endcase
        if (e.dst == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Pop and compare every freshly loaded valid ID/EX entry
    logic ld_q;
    always @(posedge clk or negedge reset) begin
        if (!reset) ld_q <= 1'b0;
        else        ld_q <= bus.ex_ready;
    end

    always @(negedge clk) begin
        if (reset && ld_q && bus.ex_valid) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("op",       bus.ex_op,       e.op);
                check("funct",    bus.ex_funct,    e.funct);
                check("rs_val",   bus.ex_rs_val,   e.rs_val);
                check("rt_val",   bus.ex_rt_val,   e.rt_val);
                check("imm",      bus.ex_imm,      e.imm);
                check("rs",       bus.ex_rs,       e.rs);
                check("rt",       bus.ex_rt,       e.rt);
                check("dst",      bus.ex_dst,      e.dst);
                check("regwrite", bus.ex_regwrite, e.rw);
                check("memread",  bus.ex_memread,  e.mr);
                check("memwrite", bus.ex_memwrite, e.mw);
                check("illegal",  bus.ex_illegal,  e.ill);
            end
        end
    end

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        @(posedge clk); #1;
        bus.wb_we = 1'b0;
    endtask

    // Hold the instruction in decode until accepted; count stall cycles
    task automatic issue(input logic [31:0] ins, input int exp_stall, input string tag);
        int  n;
        logic s;
        n = 0;
        bus.if_valid = 1'b1;
        bus.if_instr = ins;
        sb.push_back(model(ins));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s = bus.id_stall;
            @(posedge clk); #1;
            bus.wb_we = 1'b0;
            if (!s) break;
            n++;
            check({tag, "_bubble"}, bus.ex_valid, 32'd0);
        end
        check({tag, "_stalls"}, n, exp_stall);
        bus.if_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    int exp_wb_stall;

    initial begin
        bus.if_valid = 1'b0; bus.if_instr = 32'h0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
        bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'h0;
`ifdef ID_WB_BYPASS_EN
        exp_wb_stall = 0;
`else
        exp_wb_stall = 1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  bus.ex_valid,    32'd0);
        check("rst_rsval",  bus.ex_rs_val,   32'd0);
        check("rst_op",     bus.ex_op,       32'd0);
        check("rst_rw",     bus.ex_regwrite, 32'd0);
        check("rst_stall",  bus.id_stall,    32'd0);
        reset = 1'b1;

        wb_write(5'd1, 32'd10);
        wb_write(5'd2, 32'd20);
        wb_write(5'd15, 32'd31);

        // Reset asserted between edges clears ID/EX immediately
        issue(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 0, "add_pre");
        check("pre_valid", bus.ex_valid, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mrst_valid", bus.ex_valid,    32'd0);
        check("mrst_rsval", bus.ex_rs_val,   32'd0);
        check("mrst_dst",   bus.ex_dst,      32'd0);
        check("mrst_rw",    bus.ex_regwrite, 32'd0);
        if (sb.size() > 0) void'(sb.pop_front());
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        issue(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 0, "add");

        // Load-use: rs and rt-as-source stall; non-source rt and r0 do not
        issue(i_ins(6'h23, 5'd1, 5'd5, 16'd4), 0, "lw5");
        issue(r_ins(5'd5, 5'd2, 5'd6, 6'h20), 1, "add_lu");
        issue(i_ins(6'h23, 5'd1, 5'd5, 16'd8), 0, "lw5b");
        issue(i_ins(6'h2B, 5'd1, 5'd5, 16'd0), 1, "sw_lu");
        issue(i_ins(6'h23, 5'd2, 5'd4, 16'd0), 0, "lw4");
        issue(i_ins(6'h08, 5'd1, 5'd4, 16'd3), 0, "addi_norlu");
        issue(i_ins(6'h23, 5'd1, 5'd0, 16'd0), 0, "lw0");
        issue(r_ins(5'd0, 5'd2, 5'd6, 6'h22), 0, "sub_r0");

        // Same-cycle write to r15 while addi reads it
        bus.wb_we = 1'b1; bus.wb_addr = 5'd15; bus.wb_data = 32'd255;
        issue(i_ins(6'h08, 5'd15, 5'd7, 16'hFFFF), exp_wb_stall, "addi_wt");

        // Flush overrides a pending load-use hazard
        issue(i_ins(6'h23, 5'd2, 5'd5, 16'd0), 0, "lw5c");
        bus.if_valid = 1'b1; bus.if_instr = r_ins(5'd5, 5'd2, 5'd6, 6'h20); bus.flush = 1'b1;
        #1;
        check("flush_stall", bus.id_stall, 32'd0);
        @(posedge clk); #1;
        check("flush_valid", bus.ex_valid, 32'd0);
        bus.flush = 1'b0;
        issue(r_ins(5'd5, 5'd2, 5'd6, 6'h20), 0, "add_postflush");

        // Back-pressure: ID/EX holds, decode stalls
        bus.ex_ready = 1'b0;
        bus.if_valid = 1'b1; bus.if_instr = i_ins(6'h08, 5'd1, 5'd9, 16'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_stall", bus.id_stall,  32'd1);
            check("hold_valid", bus.ex_valid,  32'd1);
            check("hold_dst",   bus.ex_dst,    32'd6);
            check("hold_rtval", bus.ex_rt_val, 32'd20);
        end
        @(posedge clk); #1;
        bus.ex_ready = 1'b1;
        issue(i_ins(6'h08, 5'd1, 5'd9, 16'd5), 0, "addi_after_hold");

        issue({6'h3F, 5'd1, 5'd2, 16'h1234}, 0, "illegal");
        issue(r_ins(5'd1, 5'd2, 5'd0, 6'h20), 0, "add_r0");
        issue(i_ins(6'h04, 5'd1, 5'd2, 16'h8000), 0, "beq");

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
